// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard fields and memory status in, pipeline
// register controls and hazard statistics out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [4:0]       EX_rt;
    logic             EX_BranchTaken;
    logic             MemBusy;
    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             Freeze;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_rt, EX_BranchTaken, MemBusy,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, Freeze, MemErr,
               StallCnt, FlushCnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UsesRt, EX_MemRead, EX_rt, EX_BranchTaken, MemBusy,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, Freeze, MemErr,
               StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, taken-branch flush and data-memory freeze/timeout control.
// Define HAZARD_PERF_CNT_EN to build the saturating StallCnt/FlushCnt counters.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          Clk,
    input  logic          Rst_n,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        ERR    = 2'd2
    } state_t;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] busyCnt_q, busyCnt_d;
    logic       loadUse;
    logic       pcWrite, ifidWrite, ifidFlush, idexFlush, freeze;

    // $zero is never a real producer, and rt only matters when ID actually reads it.
    assign loadUse = bus.EX_MemRead && (bus.EX_rt != 5'd0) &&
                     ((bus.EX_rt == bus.ID_rs) ||
                      (bus.ID_UsesRt && (bus.EX_rt == bus.ID_rt)));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= RUN;
            busyCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            busyCnt_q <= busyCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busyCnt_d = busyCnt_q;
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        freeze    = 1'b1;

        case (state_q)
            RUN: begin
                if (bus.MemBusy) begin
                    state_d   = FREEZE;
                    busyCnt_d = 8'd1;
                end
            end
            FREEZE: begin
                if (!bus.MemBusy) begin
                    state_d   = RUN;
                    busyCnt_d = 8'd0;
                end else if (busyCnt_q >= TimeoutCnt) begin
                    state_d = ERR;
                end else begin
                    busyCnt_d = busyCnt_q + 8'd1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d   = RUN;
                busyCnt_d = 8'd0;
            end
        endcase

        // The cycle MemBusy drops already advances the pipeline, so deferred actions fire then.
        if (Rst_n && (state_q != ERR) && !bus.MemBusy) begin
            freeze = 1'b0;
            if (bus.EX_BranchTaken) begin
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
                ifidFlush = 1'b1;
                idexFlush = 1'b1;
            end else if (loadUse) begin
                idexFlush = 1'b1;
            end else begin
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
            end
        end
    end

    assign bus.PCWrite    = pcWrite;
    assign bus.IFID_Write = ifidWrite;
    assign bus.IFID_Flush = ifidFlush;
    assign bus.IDEX_Flush = idexFlush;
    assign bus.Freeze     = freeze;
    assign bus.MemErr     = (state_q == ERR);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt_q, flushCnt_q;
    logic             stallEvt, flushEvt;

    // A bubble without an IF/ID flush is exactly the load-use stall.
    assign stallEvt = idexFlush && !ifidFlush;
    assign flushEvt = ifidFlush;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (stallEvt && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            end
            if (flushEvt && (flushCnt_q != '1)) begin
                flushCnt_q <= flushCnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.StallCnt = stallCnt_q;
    assign bus.FlushCnt = flushCnt_q;
`else
    assign bus.StallCnt = {CNT_W{1'b0}};
    assign bus.FlushCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors queue their expected
// outputs, and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, Freeze, MemErr}
    localparam logic [5:0] NORM  = 6'b110000;
    localparam logic [5:0] STALL = 6'b000100;
    localparam logic [5:0] BRFL  = 6'b111100;
    localparam logic [5:0] FRZ   = 6'b000010;
    localparam logic [5:0] ERRS  = 6'b000011;
    localparam logic [5:0] RSTO  = 6'b000010;

    typedef struct {
        string      name;
        logic [5:0] ctl;
        int         stall;
        int         flush;
    } exp_t;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    exp_t expQ[$];
    exp_t monE;
    int   compared   = 0;
    int   mismatched = 0;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic int cnt(input int v);
        return PERF ? v : 0;
    endfunction

    // Drive one cycle's inputs just after the edge and queue what that cycle must show.
    task automatic applyStimulus(input string name, input logic rstN, input logic busy,
                                 input logic br, input logic memRead, input logic [4:0] exRt,
                                 input logic [4:0] idRs, input logic [4:0] idRt,
                                 input logic usesRt, input logic [5:0] ctl,
                                 input int stall, input int flush);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst_n              = rstN;
        bus.MemBusy        = busy;
        bus.EX_BranchTaken = br;
        bus.EX_MemRead     = memRead;
        bus.EX_rt          = exRt;
        bus.ID_rs          = idRs;
        bus.ID_rt          = idRt;
        bus.ID_UsesRt      = usesRt;
        e.name  = name;
        e.ctl   = ctl;
        e.stall = cnt(stall);
        e.flush = cnt(flush);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] got;
        got = {bus.PCWrite, bus.IFID_Write, bus.IFID_Flush, bus.IDEX_Flush,
               bus.Freeze, bus.MemErr};
        compared++;
        if (got !== e.ctl) begin
            mismatched++;
            $display("[TB] FAIL %s ctl: got %b expected %b", e.name, got, e.ctl);
        end
        compared++;
        if (bus.StallCnt !== CNT_W'(e.stall)) begin
            mismatched++;
            $display("[TB] FAIL %s StallCnt: got %0d expected %0d", e.name, bus.StallCnt, e.stall);
        end
        compared++;
        if (bus.FlushCnt !== CNT_W'(e.flush)) begin
            mismatched++;
            $display("[TB] FAIL %s FlushCnt: got %0d expected %0d", e.name, bus.FlushCnt, e.flush);
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (expQ.size() > 0) begin
                monE = expQ.pop_front();
                checkOutput(monE);
            end
        end
    end

    initial begin
        bus.MemBusy        = 1'b0;
        bus.EX_BranchTaken = 1'b0;
        bus.EX_MemRead     = 1'b0;
        bus.EX_rt          = 5'd0;
        bus.ID_rs          = 5'd0;
        bus.ID_rt          = 5'd0;
        bus.ID_UsesRt      = 1'b0;

        //              name          rst bsy br  mr  exRt idRs idRt use  ctl   stl fl
        applyStimulus("reset",       0,  0,  0,  0,  0,   0,   0,   0,  RSTO,  0, 0);
        applyStimulus("idle",        1,  0,  0,  0,  0,   0,   0,   0,  NORM,  0, 0);
        applyStimulus("lu_rs",       1,  0,  0,  1,  8,   8,   0,   0,  STALL, 0, 0);
        applyStimulus("after_lu",    1,  0,  0,  0,  8,   8,   0,   0,  NORM,  1, 0);
        applyStimulus("rt_nouse",    1,  0,  0,  1,  9,   3,   9,   0,  NORM,  1, 0);
        applyStimulus("rt_use",      1,  0,  0,  1,  9,   3,   9,   1,  STALL, 1, 0);
        applyStimulus("zero_reg",    1,  0,  0,  1,  0,   0,   0,   1,  NORM,  2, 0);
        applyStimulus("br_lu",       1,  0,  1,  1,  8,   8,   0,   0,  BRFL,  2, 0);
        applyStimulus("post_br",     1,  0,  0,  0,  0,   0,   0,   0,  NORM,  2, 1);
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus("freeze",  1,  1,  1,  1,  8,   8,   0,   0,  FRZ,   2, 1);
        end
        applyStimulus("freeze_exit", 1,  0,  1,  1,  8,   8,   0,   0,  BRFL,  2, 1);
        applyStimulus("post_exit",   1,  0,  0,  0,  0,   0,   0,   0,  NORM,  2, 2);
        for (int i = 0; i <= TIMEOUT; i++) begin
            applyStimulus("to_busy", 1,  1,  0,  0,  0,   0,   0,   0,  FRZ,   2, 2);
        end
        applyStimulus("err_busy",    1,  1,  0,  0,  0,   0,   0,   0,  ERRS,  2, 2);
        applyStimulus("err_br",      1,  0,  1,  0,  0,   0,   0,   0,  ERRS,  2, 2);
        applyStimulus("err_lu",      1,  0,  0,  1,  8,   8,   0,   0,  ERRS,  2, 2);
        applyStimulus("rst_err",     0,  0,  0,  0,  0,   0,   0,   0,  RSTO,  0, 0);
        applyStimulus("rel",         1,  0,  0,  0,  0,   0,   0,   0,  NORM,  0, 0);
        applyStimulus("lu2",         1,  0,  0,  1,  5,   5,   0,   0,  STALL, 0, 0);
        applyStimulus("frz_a",       1,  1,  0,  0,  0,   0,   0,   0,  FRZ,   1, 0);
        applyStimulus("frz_b",       1,  1,  0,  0,  0,   0,   0,   0,  FRZ,   1, 0);
        applyStimulus("rst_frz",     0,  1,  0,  0,  0,   0,   0,   0,  RSTO,  0, 0);
        applyStimulus("rel2",        1,  0,  0,  0,  0,   0,   0,   0,  NORM,  0, 0);
        applyStimulus("busy_again",  1,  1,  0,  0,  0,   0,   0,   0,  FRZ,   0, 0);
        applyStimulus("drop_again",  1,  0,  0,  0,  0,   0,   0,   0,  NORM,  0, 0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(negedge Clk);
        end
        @(posedge Clk);
        if (expQ.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
